// File: rtl/bus_pkg.sv
// Shared bus definitions: mux select width, idle code, bus source codes and
// the arbiter state encoding.
package bus_pkg;

  localparam int SEL_W = 5;
  localparam int ID_W  = 3;

  localparam logic [SEL_W-1:0] IDLE_SEL    = 5'd31;
  localparam logic [SEL_W-1:0] SRC_PC      = 5'd20;
  localparam logic [SEL_W-1:0] SRC_MDR     = 5'd21;
  localparam logic [SEL_W-1:0] SRC_IN_PORT = 5'd22;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_t;

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Rotating priority encoder: first set request at or after start, wrapping.
// With BUS_ARB_FIXED_PRIO_EN defined it is a plain priority encoder (index 0 wins).
module rr_pick
  import bus_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    start,
  output logic [NUM_REQ-1:0] onehot,
  output logic [ID_W-1:0]    idx,
  output logic               any
);

  localparam int unsigned N = NUM_REQ;

`ifdef BUS_ARB_FIXED_PRIO_EN
  logic unused_start;
  assign unused_start = ^start;
`endif

  always_comb begin
    int unsigned k;
    k      = 0;
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
`ifdef BUS_ARB_FIXED_PRIO_EN
      k = i;
`else
      k = (32'(start) + i) % N;
`endif
      if (!any && req[k]) begin
        any       = 1'b1;
        idx       = ID_W'(k);
        onehot[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Internal bus arbiter: round-robin with bounded hold time, drives bus mux select.
// Define BUS_ARB_FIXED_PRIO_EN for fixed priority (index 0 highest).
module bus_arbiter #(
  parameter int                       NUM_REQ  = 4,
  parameter int                       SEL_W    = bus_pkg::SEL_W,
  parameter int                       MAX_HOLD = 4,
  parameter logic [SEL_W-1:0]         IDLE_SEL = bus_pkg::IDLE_SEL
) (
  input  logic                       clock,
  input  logic                       clear,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*SEL_W-1:0]   req_sel,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         grant,
  output logic [2:0]                 grant_id,
  output logic [SEL_W-1:0]           select,
  output logic                       bus_valid
);

  import bus_pkg::*;

  localparam int HC_W = $clog2(MAX_HOLD + 1);
  localparam logic [HC_W-1:0] HOLD_MAX  = HC_W'(MAX_HOLD);
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(MAX_HOLD - 1);

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [ID_W-1:0]      grant_id_q, grant_id_d;
  logic [HC_W-1:0]      hold_cnt_q, hold_cnt_d;
  logic [ID_W-1:0]      last_id_q, last_id_d;

  logic [NUM_REQ-1:0]   pick_req, pick_onehot;
  logic [ID_W-1:0]      pick_idx, pick_start;
  logic                 pick_any;
  logic                 owner_req, owner_last, preempt, release_now;

  // While owned the current owner is masked out, so the same search serves
  // both the idle grant and the back-to-back hand-over.
  assign pick_req   = (state_q == OWNED) ? (req & ~grant_q) : req;
  assign pick_start = (last_id_q == ID_W'(NUM_REQ - 1)) ? '0 : last_id_q + ID_W'(1);

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req    (pick_req),
    .start  (pick_start),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  assign owner_req  = |(req & grant_q);
  assign owner_last = |(req_last & grant_q);

`ifdef BUS_ARB_FIXED_PRIO_EN
  // grant_q - 1 on a one-hot value masks exactly the higher-priority indices.
  assign preempt = |(req & (grant_q - NUM_REQ'(1)));
`else
  assign preempt = pick_any;
`endif

  assign release_now = !owner_req || owner_last || ((hold_cnt_q >= HOLD_LAST) && preempt);

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    grant_id_d = grant_id_q;
    hold_cnt_d = hold_cnt_q;
    last_id_d  = last_id_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d    = OWNED;
          grant_d    = pick_onehot;
          grant_id_d = pick_idx;
          hold_cnt_d = '0;
          last_id_d  = pick_idx;
        end
      end
      OWNED: begin
        if (release_now) begin
          hold_cnt_d = '0;
          if (pick_any) begin
            grant_d    = pick_onehot;
            grant_id_d = pick_idx;
            last_id_d  = pick_idx;
          end else begin
            state_d    = IDLE;
            grant_d    = '0;
            grant_id_d = '0;
          end
        end else if (hold_cnt_q != HOLD_MAX) begin
          hold_cnt_d = hold_cnt_q + HC_W'(1);
        end
      end
      default: begin
        state_d    = IDLE;
        grant_d    = '0;
        grant_id_d = '0;
        hold_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      grant_id_q <= '0;
      hold_cnt_q <= '0;
      last_id_q  <= ID_W'(NUM_REQ - 1);
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      hold_cnt_q <= hold_cnt_d;
      last_id_q  <= last_id_d;
    end
  end

  always_comb begin
    select = IDLE_SEL;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) select = req_sel[i*SEL_W +: SEL_W];
    end
  end

  assign grant     = grant_q;
  assign grant_id  = grant_id_q;
  assign bus_valid = (state_q == OWNED);

  grant_onehot_a: assert property (@(posedge clock) disable iff (clear) $onehot0(grant_q));

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter (NUM_REQ=4, MAX_HOLD=4).
module tb_bus_arbiter;

  logic        clock;
  logic        clear;
  logic [3:0]  req;
  logic [19:0] req_sel;
  logic [3:0]  req_last;
  logic [3:0]  grant;
  logic [2:0]  grant_id;
  logic [4:0]  select;
  logic        bus_valid;

  int errs;
  int checks;

  bus_arbiter #(
    .NUM_REQ (4),
    .SEL_W   (5),
    .MAX_HOLD(4),
    .IDLE_SEL(5'd31)
  ) dut (
    .clock    (clock),
    .clear    (clear),
    .req      (req),
    .req_sel  (req_sel),
    .req_last (req_last),
    .grant    (grant),
    .grant_id (grant_id),
    .select   (select),
    .bus_valid(bus_valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset;
    req      = '0;
    req_last = '0;
    clear    = 1'b1;
    step();
    clear    = 1'b0;
  endtask

  task automatic test_reset;
    clear    = 1'b1;
    req      = '0;
    req_last = '0;
    req_sel  = {5'd23, 5'd22, 5'd21, 5'd20};
    #12;
    checks++; if (grant !== 4'b0000) begin errs++; $display("FAIL reset_grant: got %b want 0000", grant); end
    checks++; if (grant_id !== 3'd0) begin errs++; $display("FAIL reset_grant_id: got %0d want 0", grant_id); end
    checks++; if (select !== 5'd31) begin errs++; $display("FAIL reset_select: got %0d want 31", select); end
    checks++; if (bus_valid !== 1'b0) begin errs++; $display("FAIL reset_valid: got %b want 0", bus_valid); end
    step();
    clear = 1'b0;
    req   = 4'b0100;
    step();
    checks++; if (grant !== 4'b0100) begin errs++; $display("FAIL reset_pre_grant: got %b want 0100", grant); end
    checks++; if (select !== 5'd22) begin errs++; $display("FAIL reset_pre_select: got %0d want 22", select); end
    step();
    #3;
    clear = 1'b1;
    #1;
    checks++; if (grant !== 4'b0000) begin errs++; $display("FAIL async_grant: got %b want 0000", grant); end
    checks++; if (select !== 5'd31) begin errs++; $display("FAIL async_select: got %0d want 31", select); end
    checks++; if (bus_valid !== 1'b0) begin errs++; $display("FAIL async_valid: got %b want 0", bus_valid); end
    step();
    clear = 1'b0;
    step();
    checks++; if (grant !== 4'b0100) begin errs++; $display("FAIL post_reset_grant: got %b want 0100", grant); end
    checks++; if (grant_id !== 3'd2) begin errs++; $display("FAIL post_reset_id: got %0d want 2", grant_id); end
    req = '0;
    step();
    checks++; if (grant !== 4'b0000) begin errs++; $display("FAIL post_reset_drop: got %b want 0000", grant); end
  endtask

  task automatic test_single;
    do_reset();
    req_sel = {5'd23, 5'd22, 5'd20, 5'd20};
    req     = 4'b0010;
    for (int c = 1; c <= 3; c++) begin
      step();
      checks++; if (grant !== 4'b0010) begin errs++; $display("FAIL single_grant c%0d: got %b want 0010", c, grant); end
      checks++; if (select !== 5'd20) begin errs++; $display("FAIL single_select c%0d: got %0d want 20", c, select); end
      checks++; if (bus_valid !== 1'b1) begin errs++; $display("FAIL single_valid c%0d: got %b want 1", c, bus_valid); end
      if (c == 3) req_last = 4'b0010;
    end
    step();
    req      = '0;
    req_last = '0;
    checks++; if (grant !== 4'b0000) begin errs++; $display("FAIL single_idle_grant: got %b want 0000", grant); end
    checks++; if (select !== 5'd31) begin errs++; $display("FAIL single_idle_select: got %0d want 31", select); end
    checks++; if (bus_valid !== 1'b0) begin errs++; $display("FAIL single_idle_valid: got %b want 0", bus_valid); end
    // req_last together with dropping req: one release, no regrant.
    req = 4'b0010;
    step();
    req      = 4'b0000;
    req_last = 4'b0010;
    step();
    req_last = '0;
    checks++; if (grant !== 4'b0000) begin errs++; $display("FAIL last_and_drop: got %b want 0000", grant); end
    step();
    checks++; if (grant !== 4'b0000) begin errs++; $display("FAIL last_and_drop_hold: got %b want 0000", grant); end
  endtask

  task automatic test_round_robin;
    int exp_ord[5];
    logic [3:0] eg;
    exp_ord = '{0, 1, 2, 3, 0};
    do_reset();
    req_sel = {5'd23, 5'd22, 5'd21, 5'd20};
    req     = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      step();
      eg = 4'b0001 << exp_ord[n];
      checks++; if (grant !== eg) begin errs++; $display("FAIL rr_grant n%0d: got %b want %b", n, grant, eg); end
      checks++; if (grant_id !== 3'(exp_ord[n])) begin errs++; $display("FAIL rr_id n%0d: got %0d want %0d", n, grant_id, exp_ord[n]); end
      checks++; if (select !== 5'(20 + exp_ord[n])) begin errs++; $display("FAIL rr_select n%0d: got %0d want %0d", n, select, 20 + exp_ord[n]); end
      checks++; if (bus_valid !== 1'b1) begin errs++; $display("FAIL rr_valid n%0d: got %b want 1", n, bus_valid); end
      req_last = eg;
    end
    req      = '0;
    req_last = '0;
    step();
    checks++; if (grant !== 4'b0000) begin errs++; $display("FAIL rr_idle: got %b want 0000", grant); end
  endtask

  task automatic test_preemption;
    int eo;
    do_reset();
    req = 4'b0001;
    for (int c = 1; c <= 9; c++) begin
      step();
      eo = (c <= 4) ? 0 : ((c <= 8) ? 3 : 0);
      checks++; if (grant_id !== 3'(eo) || grant !== (4'b0001 << eo)) begin
        errs++; $display("FAIL preempt_owner c%0d: got id %0d grant %b want id %0d", c, grant_id, grant, eo);
      end
      if (c == 1) req = 4'b1001;
    end
    req = '0;
    step();
    checks++; if (grant !== 4'b0000) begin errs++; $display("FAIL preempt_idle: got %b want 0000", grant); end
  endtask

  task automatic test_sole_owner;
    do_reset();
    req_sel = {5'd23, 5'd22, 5'd21, 5'd20};
    req     = 4'b0100;
    for (int c = 1; c <= 10; c++) begin
      step();
      checks++; if (grant !== 4'b0100) begin errs++; $display("FAIL sole_grant c%0d: got %b want 0100", c, grant); end
      checks++; if (select !== 5'd22) begin errs++; $display("FAIL sole_select c%0d: got %0d want 22", c, select); end
      req_last = (c == 5) ? 4'b0001 : 4'b0000;
    end
    req = '0;
    step();
    checks++; if (grant !== 4'b0000) begin errs++; $display("FAIL sole_drop_grant: got %b want 0000", grant); end
    checks++; if (bus_valid !== 1'b0) begin errs++; $display("FAIL sole_drop_valid: got %b want 0", bus_valid); end
    checks++; if (select !== 5'd31) begin errs++; $display("FAIL sole_drop_select: got %0d want 31", select); end
  endtask

`ifdef BUS_ARB_FIXED_PRIO_EN
  task automatic test_fixed_prio;
    int eo;
    do_reset();
    req = 4'b1010;
    for (int c = 1; c <= 9; c++) begin
      step();
      eo = (c <= 4) ? 1 : 0;
      checks++; if (grant_id !== 3'(eo)) begin errs++; $display("FAIL fixed_owner c%0d: got %0d want %0d", c, grant_id, eo); end
      if (c == 1) req = 4'b1011;
    end
    req = 4'b1010;
    step();
    checks++; if (grant_id !== 3'd1) begin errs++; $display("FAIL fixed_back_to_1: got %0d want 1", grant_id); end
    req = 4'b1000;
    step();
    checks++; if (grant_id !== 3'd3) begin errs++; $display("FAIL fixed_to_3: got %0d want 3", grant_id); end
    req = '0;
    step();
  endtask
`endif

  initial begin
    errs   = 0;
    checks = 0;
    test_reset();
    test_single();
    test_sole_owner();
`ifdef BUS_ARB_FIXED_PRIO_EN
    test_fixed_prio();
`else
    test_round_robin();
    test_preemption();
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
